turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/game_pkg.sv | 16 +
 rtl/next_player_finder.sv | 31 +++
 rtl/turn_scheduler.sv | 178 +++++++++++++++++
 tb/tb_turn_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and default widths for the turn scheduler
package game_pkg;

  localparam int PLAYER_ID_W  = 3;
  localparam int STEP_TIMER_W = 4;
  localparam int ROUND_W      = 12;
  localparam int NPC_ID       = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

endpackage

// File: rtl/next_player_finder.sv
// rtl/next_player_finder.sv - round-robin successor search over the alive mask
module next_player_finder
  import game_pkg::*;
#(
  parameter int N = 7,
  parameter int W = PLAYER_ID_W
) (
  input  logic [W-1:0] cur_id_i,
  input  logic [N-1:0] alive_mask_i,
  output logic [W-1:0] next_id_o
);

  logic [W-1:0] above_id;
  logic [W-1:0] lowest_id;

  // Scan downwards so the last hit is the lowest alive ID (overall and above cur_id_i)
  always_comb begin
    above_id  = W'(NPC_ID);
    lowest_id = W'(NPC_ID);
    for (int i = N; i >= 1; i--) begin
      if (alive_mask_i[i-1]) begin
        lowest_id = W'(i);
        if (W'(i) > cur_id_i) above_id = W'(i);
      end
    end
    if (above_id != W'(NPC_ID))       next_id_o = above_id;
    else if (lowest_id != W'(NPC_ID)) next_id_o = lowest_id;
    else                              next_id_o = cur_id_i;
  end

endmodule

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - turn/round/timer sequencing for a multi-player game
module turn_scheduler
  import game_pkg::*;
#(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = PLAYER_ID_W,
  parameter int MAX_STEP_TIME       = 15,
  parameter int LOG2_MAX_STEP_TIME  = STEP_TIMER_W,
  parameter int LOG2_MAX_ROUND      = ROUND_W,
  parameter int TICKS_PER_SEC       = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [LOG2_MAX_PLAYER_CNT-1:0] first_player,
  input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
  input  logic                           move_done,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           timeout,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner,
  output logic [1:0]                     state
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [LOG2_MAX_ROUND-1:0] ROUND_MAX = '1;
  localparam logic [LOG2_MAX_STEP_TIME-1:0] STEP_LOAD = LOG2_MAX_STEP_TIME'(MAX_STEP_TIME);

  typedef logic [LOG2_MAX_PLAYER_CNT-1:0] pid_t;

  state_e                        state_q, state_d;
  pid_t                          cur_q, cur_d;
  pid_t                          winner_q, winner_d;
  logic [LOG2_MAX_STEP_TIME-1:0] timer_q, timer_d;
  logic [LOG2_MAX_ROUND-1:0]     round_q, round_d;
  logic [TICK_W-1:0]             tick_q, tick_d;
  logic                          turn_start_q, turn_start_d;
  logic                          timeout_q, timeout_d;

  pid_t succ_id, first_succ, lowest_alive;
  logic enough_alive, game_start, tick_hit, expire;
  logic cur_alive, first_alive;
  logic [MAX_PLAYER_CNT:0] mask_ext;

  next_player_finder #(.N(MAX_PLAYER_CNT), .W(LOG2_MAX_PLAYER_CNT)) u_next_finder (
    .cur_id_i     (cur_q),
    .alive_mask_i (alive_mask),
    .next_id_o    (succ_id)
  );

  next_player_finder #(.N(MAX_PLAYER_CNT), .W(LOG2_MAX_PLAYER_CNT)) u_first_finder (
    .cur_id_i     (first_player),
    .alive_mask_i (alive_mask),
    .next_id_o    (first_succ)
  );

  // Alive-set summaries; bit 0 of the extended mask stands for the NPC and is never alive
  always_comb begin
    mask_ext     = {alive_mask, 1'b0};
    enough_alive = ($countones(alive_mask) >= 2);
    cur_alive    = mask_ext[cur_q];
    first_alive  = mask_ext[first_player];
    game_start   = start && enough_alive;
    tick_hit     = (tick_q == TICK_W'(TICKS_PER_SEC - 1));
    expire       = tick_hit && (timer_q == LOG2_MAX_STEP_TIME'(1));
    lowest_alive = pid_t'(NPC_ID);
    for (int i = MAX_PLAYER_CNT; i >= 1; i--) begin
      if (alive_mask[i-1]) lowest_alive = pid_t'(i);
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: start overrides everything, then game-over, then turn-ending events
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = enough_alive ? ST_RUNNING : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUNNING: begin
          if (!enough_alive)                         state_d = ST_OVER;
          else if (move_done || expire || !cur_alive) state_d = ST_ADVANCE;
        end
        ST_ADVANCE: state_d = enough_alive ? ST_RUNNING : ST_OVER;
        default:    state_d = state_q;
      endcase
    end
  end

  // Datapath next values: turn entry, tick/timer countdown, turn hand-over, winner capture
  always_comb begin
    cur_d        = cur_q;
    winner_d     = winner_q;
    timer_d      = timer_q;
    round_d      = round_q;
    tick_d       = tick_q;
    turn_start_d = 1'b0;
    timeout_d    = 1'b0;
    if (game_start) begin
      cur_d        = first_alive ? first_player : first_succ;
      round_d      = LOG2_MAX_ROUND'(1);
      timer_d      = STEP_LOAD;
      tick_d       = '0;
      turn_start_d = 1'b1;
      winner_d     = pid_t'(NPC_ID);
    end else if (!start) begin
      case (state_q)
        ST_RUNNING: begin
          if (state_d == ST_OVER) begin
            winner_d = lowest_alive;
          end else begin
            if (tick_hit) begin
              tick_d  = '0;
              timer_d = timer_q - 1'b1;
            end else begin
              tick_d  = tick_q + 1'b1;
            end
            timeout_d = expire && !move_done;
          end
        end
        ST_ADVANCE: begin
          if (state_d == ST_OVER) begin
            winner_d = lowest_alive;
          end else begin
            cur_d        = succ_id;
            if (succ_id <= cur_q && round_q != ROUND_MAX) round_d = round_q + 1'b1;
            timer_d      = STEP_LOAD;
            tick_d       = '0;
            turn_start_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_q        <= '0;
      winner_q     <= '0;
      timer_q      <= '0;
      round_q      <= '0;
      tick_q       <= '0;
      turn_start_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cur_q        <= cur_d;
      winner_q     <= winner_d;
      timer_q      <= timer_d;
      round_q      <= round_d;
      tick_q       <= tick_d;
      turn_start_q <= turn_start_d;
      timeout_q    <= timeout_d;
    end
  end

  // Outputs; next_player is held at 0 while idle so reset leaves every output at 0
  always_comb begin
    state          = state_q;
    current_player = cur_q;
    next_player    = (state_q == ST_IDLE) ? pid_t'(NPC_ID) : succ_id;
    step_timer     = timer_q;
    round          = round_q;
    turn_start     = turn_start_q;
    timeout        = timeout_q;
    winner         = (state_q == ST_OVER) ? winner_q : pid_t'(NPC_ID);
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - self-checking bench for turn_scheduler
module tb_turn_scheduler;

  localparam int NP  = 7;
  localparam int MST = 3;
  localparam int TPS = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] first_player = 3'd0;
  logic [6:0] alive_mask = 7'd0;
  logic       move_done = 1'b0;
  logic [2:0] current_player, next_player, winner;
  logic [3:0] step_timer;
  logic [11:0] round;
  logic       turn_start, timeout;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  turn_scheduler #(
    .MAX_PLAYER_CNT(7), .LOG2_MAX_PLAYER_CNT(3), .MAX_STEP_TIME(MST),
    .LOG2_MAX_STEP_TIME(4), .LOG2_MAX_ROUND(12), .TICKS_PER_SEC(TPS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .first_player(first_player),
    .alive_mask(alive_mask), .move_done(move_done), .current_player(current_player),
    .next_player(next_player), .step_timer(step_timer), .round(round),
    .turn_start(turn_start), .timeout(timeout), .winner(winner), .state(state)
  );

  always #5 clock = ~clock;

  // Behavioural model: turn age in cycles, timer derived from age, round-robin by ID search
  int m_state = 0, m_cur = 0, m_round = 0, m_timer = 0, m_age = 0;
  int m_ts = 0, m_to = 0, m_win = 0;

  function automatic int n_alive(logic [6:0] m);
    int c = 0;
    for (int i = 0; i < NP; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic bit is_alive(logic [6:0] m, int id);
    return (id != 0) && m[id-1];
  endfunction

  function automatic int succ(int cur, logic [6:0] m);
    for (int k = 1; k <= NP; k++) begin
      int id = (cur + k - 1) % NP + 1;
      if (m[id-1]) return id;
    end
    return cur;
  endfunction

  function automatic int sole(logic [6:0] m);
    for (int i = 1; i <= NP; i++) if (m[i-1]) return i;
    return 0;
  endfunction

  task automatic model_step();
    int prev_state = m_state;
    m_ts = 0;
    m_to = 0;
    if (start) begin
      if (n_alive(alive_mask) >= 2) begin
        m_state = 1;
        m_cur   = is_alive(alive_mask, int'(first_player)) ? int'(first_player)
                                                           : succ(int'(first_player), alive_mask);
        m_round = 1; m_timer = MST; m_age = 0; m_ts = 1; m_win = 0;
      end else begin
        m_state = 0;
      end
    end else if (prev_state == 1) begin
      if (n_alive(alive_mask) < 2) begin
        m_state = 3; m_win = sole(alive_mask);
      end else begin
        bit expired;
        m_age++;
        m_timer = MST - m_age / TPS;
        expired = (m_age == MST * TPS);
        if (move_done || expired || !is_alive(alive_mask, m_cur)) begin
          m_state = 2;
          m_to = (expired && !move_done) ? 1 : 0;
        end
      end
    end else if (prev_state == 2) begin
      if (n_alive(alive_mask) < 2) begin
        m_state = 3; m_win = sole(alive_mask);
      end else begin
        int nc = succ(m_cur, alive_mask);
        if (nc <= m_cur && m_round < 4095) m_round++;
        m_cur = nc; m_timer = MST; m_age = 0; m_ts = 1; m_state = 1;
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_cur = 0; m_round = 0; m_timer = 0; m_age = 0;
      m_ts = 0; m_to = 0; m_win = 0;
    end else begin
      model_step();
    end
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    check("m.state", int'(state), m_state);
    check("m.current", int'(current_player), m_cur);
    check("m.next", int'(next_player), (m_state == 0) ? 0 : succ(m_cur, alive_mask));
    check("m.timer", int'(step_timer), m_timer);
    check("m.round", int'(round), m_round);
    check("m.turn_start", int'(turn_start), m_ts);
    check("m.timeout", int'(timeout), m_to);
    check("m.winner", int'(winner), (m_state == 3) ? m_win : 0);
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_start(logic [6:0] m, logic [2:0] f);
    alive_mask = m; first_player = f; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int n;
    cyc(2);
    check("reset.state", int'(state), 0);
    check("reset.next", int'(next_player), 0);
    reset_n = 1'b1;
    cyc();

    // Basic rotation and round wrap
    do_start(7'b0000111, 3'd2);
    check("s1.state", int'(state), 1);
    check("s1.cur", int'(current_player), 2);
    check("s1.round", int'(round), 1);
    check("s1.timer", int'(step_timer), 3);
    check("s1.ts", int'(turn_start), 1);
    cyc();
    check("s1.ts_pulse", int'(turn_start), 0);
    move_done = 1'b1; cyc(); move_done = 1'b0;
    check("s1.adv", int'(state), 2);
    cyc();
    check("s1.cur3", int'(current_player), 3);
    move_done = 1'b1; cyc(); move_done = 1'b0; cyc();
    check("s1.cur1", int'(current_player), 1);
    check("s1.round2", int'(round), 2);

    // Timeout latency, restarting from a running game
    do_start(7'b0000111, 3'd1);
    check("s2.ts", int'(turn_start), 1);
    n = 0;
    while (timeout !== 1'b1 && n < 20) begin
      cyc(); n++;
    end
    check("s2.latency", n, 12);
    cyc();
    check("s2.new_ts", int'(turn_start), 1);
    check("s2.new_timer", int'(step_timer), 3);
    check("s2.new_cur", int'(current_player), 2);

    // Sparse alive set, dead first player
    do_start(7'b1000001, 3'd3);
    check("s3.cur", int'(current_player), 7);
    move_done = 1'b1; cyc(); move_done = 1'b0; cyc();
    check("s3.cur1", int'(current_player), 1);
    check("s3.round", int'(round), 2);

    // move_done coinciding with the expiring tick
    do_start(7'b0000111, 3'd1);
    cyc(11);
    check("s4.timer1", int'(step_timer), 1);
    move_done = 1'b1; cyc(); move_done = 1'b0;
    check("s4.timeout", int'(timeout), 0);
    check("s4.adv", int'(state), 2);
    cyc();
    check("s4.running", int'(state), 1);
    check("s4.cur", int'(current_player), 2);

    // Current player dies mid-turn
    cyc(2);
    alive_mask = 7'b0000101;
    cyc(2);
    check("s5.cur", int'(current_player), 3);

    // Game over and a start with too few players
    cyc(2);
    alive_mask = 7'b0000100;
    cyc();
    check("s6.over", int'(state), 3);
    check("s6.winner", int'(winner), 3);
    start = 1'b1; cyc(); start = 1'b0;
    check("s6.idle", int'(state), 0);
    check("s6.winner0", int'(winner), 0);

    // Asynchronous reset mid-turn
    do_start(7'b0000111, 3'd1);
    cyc(4);
    check("s7.timer2", int'(step_timer), 2);
    #1 reset_n = 1'b0;
    #1;
    check("s7.state", int'(state), 0);
    check("s7.cur", int'(current_player), 0);
    check("s7.next", int'(next_player), 0);
    check("s7.timer", int'(step_timer), 0);
    check("s7.round", int'(round), 0);
    check("s7.pulses", int'({turn_start, timeout}), 0);
    check("s7.winner", int'(winner), 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
